// File: rtl/mem_ctrl.sv
// Data-memory access controller: stalls the pipeline while one load/store is in flight.
// Optional watchdog abandons an unacknowledged access; enable with `define MEM_CTRL_TIMEOUT_EN.
module mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_ld_or_ldr,
  input  logic        op_st,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        timeout_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_check
    $error("mem_ctrl: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;

`ifdef MEM_CTRL_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d       = state_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (op_ld_or_ldr || op_st) begin
          state_d     = BUSY;
          mem_addr_d  = addr;
          mem_wdata_d = wdata;
          // A load wins when both op flags are raised.
          mem_we_d    = op_st && !op_ld_or_ldr;
`ifdef MEM_CTRL_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = DONE;
          if (!mem_we_q) begin
            rdata_d       = mem_rdata;
            rdata_valid_d = 1'b1;
          end
        end
`ifdef MEM_CTRL_TIMEOUT_EN
        else if (cnt_q == TO_LIMIT) begin
          state_d       = DONE;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      DONE: begin
        // Ops seen here are ignored; the pipeline re-presents them in IDLE.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
      cnt_q         <= 8'd0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
`ifdef MEM_CTRL_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  // Stall covers the issue cycle and all of BUSY; DONE lets the pipeline advance once.
  assign stall       = ((state_q == IDLE) && (op_ld_or_ldr || op_st)) || (state_q == BUSY);
  assign mem_req     = (state_q == BUSY);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
`ifdef MEM_CTRL_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: request/read-data scoreboard plus per-access cycle counts.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_ld_or_ldr, op_st;
  logic [31:0] addr, wdata;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata, rdata;
  logic        rdata_valid, timeout_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        we;
  } txn_t;

  txn_t        txq[$];
  logic [31:0] rdq[$];

  int stall_cnt, req_cnt, valid_cnt, terr_cnt, burst_cnt;
  logic        req_prev = 1'b0;
  txn_t        held;

  always #5 clk = ~clk;

  mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_ld_or_ldr(op_ld_or_ldr), .op_st(op_st),
    .addr(addr), .wdata(wdata), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    stall_cnt = 0; req_cnt = 0; valid_cnt = 0; terr_cnt = 0; burst_cnt = 0;
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard when the DUT acts.
  always @(negedge clk) begin
    if (stall === 1'b1) stall_cnt++;
    if (mem_req === 1'b1) req_cnt++;
    if (rdata_valid === 1'b1) valid_cnt++;
    if (timeout_err === 1'b1) terr_cnt++;
    if (mem_req === 1'b1 && !req_prev) begin
      burst_cnt++;
      if (txq.size() == 0) chk("unexpected_req", 32'(mem_req), 32'd0);
      else begin
        held = txq.pop_front();
        chk("req_addr", mem_addr, held.a);
        chk("req_we", 32'(mem_we), 32'(held.we));
        if (held.we) chk("req_wdata", mem_wdata, held.d);
      end
    end else if (mem_req === 1'b1) begin
      chk("busy_addr_stable", mem_addr, held.a);
      chk("busy_we_stable", 32'(mem_we), 32'(held.we));
      if (held.we) chk("busy_wdata_stable", mem_wdata, held.d);
    end
    if (rdata_valid === 1'b1) begin
      if (rdq.size() == 0) chk("unexpected_rdata_valid", 32'(rdata_valid), 32'd0);
      else chk("rdata", rdata, rdq.pop_front());
    end
    req_prev = (mem_req === 1'b1);
  end

  // One complete access starting in IDLE; returns in IDLE. ack_at counts BUSY cycles from 1.
  task automatic access(input logic ld, input logic st, input logic [31:0] a,
                        input logic [31:0] d, input int ack_at, input logic [31:0] rd);
    txn_t t;
    clr_counts();
    op_ld_or_ldr = ld; op_st = st; addr = a; wdata = d;
    t.a = a; t.d = d; t.we = st && !ld;
    txq.push_back(t);
    if (ld) rdq.push_back(rd);
    tick();
    op_ld_or_ldr = 1'b0; op_st = 1'b0; addr = $urandom; wdata = $urandom;
    for (int i = 1; i <= 300; i++) begin
      if (i == ack_at) begin mem_ack = 1'b1; mem_rdata = rd; end
      tick();
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (i == ack_at) break;
    end
    tick();
  endtask

  logic [31:0] last_rd;

  initial begin
    rst_n = 1'b0; op_ld_or_ldr = 1'b0; op_st = 1'b0; addr = '0; wdata = '0;
    mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_stall_idle", 32'(stall), 32'd0);
    op_ld_or_ldr = 1'b1; #1;
    chk("rst_stall_follows_op", 32'(stall), 32'd1);
    op_ld_or_ldr = 1'b0;
    tick();

    // Stray ack in IDLE
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    tick();
    mem_ack = 1'b0; #1;
    chk("stray_mem_req", 32'(mem_req), 32'd0);
    chk("stray_stall", 32'(stall), 32'd0);
    chk("stray_rdata", rdata, 32'd0);
    chk("stray_rdata_valid", 32'(rdata_valid), 32'd0);
    tick();

    // Reset in the second BUSY cycle, ack one cycle later
    clr_counts();
    op_ld_or_ldr = 1'b1; addr = 32'h500;
    txq.push_back('{a: 32'h500, d: 32'h0, we: 1'b0});
    tick();
    op_ld_or_ldr = 1'b0;
    tick();
    rst_n = 1'b0; #1;
    chk("midrst_req_before", 32'(mem_req), 32'd1);
    tick();
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
    chk("midrst_req_dropped", 32'(mem_req), 32'd0);
    chk("midrst_addr_cleared", mem_addr, 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    tick();
    mem_ack = 1'b0; tick();
    chk("midrst_rdata_zero", rdata, 32'd0);
    chk("midrst_valid_cnt", 32'(valid_cnt), 32'd0);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);

    // Zero-wait load
    access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hDEAD_BEEF);
    chk("ld0_req_cycles", 32'(req_cnt), 32'd1);
    chk("ld0_stall_cycles", 32'(stall_cnt), 32'd2);
    chk("ld0_valid_pulses", 32'(valid_cnt), 32'd1);
    chk("ld0_rdata_hold", rdata, 32'hDEAD_BEEF);

    // Store with ack in the third BUSY cycle
    access(1'b0, 1'b1, 32'h40, 32'h1234_5678, 3, 32'h7777_7777);
    chk("st_req_cycles", 32'(req_cnt), 32'd3);
    chk("st_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("st_no_valid", 32'(valid_cnt), 32'd0);
    chk("st_rdata_untouched", rdata, 32'hDEAD_BEEF);

    // Both op flags set: load priority
    access(1'b1, 1'b1, 32'h80, 32'hAAAA_AAAA, 2, 32'h5555_0001);
    chk("both_valid_pulses", 32'(valid_cnt), 32'd1);
    chk("both_rdata", rdata, 32'h5555_0001);

    // Back-to-back loads, second presented during DONE
    clr_counts();
    op_ld_or_ldr = 1'b1; addr = 32'h200;
    txq.push_back('{a: 32'h200, d: 32'h0, we: 1'b0});
    rdq.push_back(32'h1111_1111);
    tick();
    op_ld_or_ldr = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0; op_ld_or_ldr = 1'b1; addr = 32'h300; #1;
    chk("b2b_stall_in_done", 32'(stall), 32'd0);
    txq.push_back('{a: 32'h300, d: 32'h0, we: 1'b0});
    rdq.push_back(32'h2222_2222);
    tick();
    chk("b2b_idle_no_req", 32'(mem_req), 32'd0);
    chk("b2b_idle_stall", 32'(stall), 32'd1);
    tick();
    op_ld_or_ldr = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("b2b_bursts", 32'(burst_cnt), 32'd2);
    chk("b2b_req_cycles", 32'(req_cnt), 32'd2);
    chk("b2b_valid_pulses", 32'(valid_cnt), 32'd2);
    last_rd = 32'h2222_2222;

`ifdef MEM_CTRL_TIMEOUT_EN
    // No ack: watchdog expires after four BUSY cycles
    clr_counts();
    op_ld_or_ldr = 1'b1; addr = 32'h600;
    txq.push_back('{a: 32'h600, d: 32'h0, we: 1'b0});
    tick();
    op_ld_or_ldr = 1'b0;
    repeat (4) tick();
    chk("to_err_pulse", 32'(timeout_err), 32'd1);
    chk("to_stall_released", 32'(stall), 32'd0);
    chk("to_req_dropped", 32'(mem_req), 32'd0);
    chk("to_no_valid", 32'(rdata_valid), 32'd0);
    tick();
    chk("to_req_cycles", 32'(req_cnt), 32'd4);
    chk("to_stall_cycles", 32'(stall_cnt), 32'd5);
    chk("to_err_pulses", 32'(terr_cnt), 32'd1);
    chk("to_rdata_held", rdata, last_rd);

    // Ack on the expiry cycle completes normally
    access(1'b1, 1'b0, 32'h700, 32'h0, 4, 32'h0BAD_F00D);
    chk("to_ack_wins_err", 32'(terr_cnt), 32'd0);
    chk("to_ack_wins_valid", 32'(valid_cnt), 32'd1);
    chk("to_ack_wins_rdata", rdata, 32'h0BAD_F00D);
`else
    // No watchdog: request is held until the ack finally arrives
    clr_counts();
    op_ld_or_ldr = 1'b1; addr = 32'h600;
    txq.push_back('{a: 32'h600, d: 32'h0, we: 1'b0});
    rdq.push_back(32'h0BAD_F00D);
    tick();
    op_ld_or_ldr = 1'b0;
    repeat (120) tick();
    chk("nto_stall_held", 32'(stall), 32'd1);
    chk("nto_req_held", 32'(mem_req), 32'd1);
    chk("nto_stall_cycles", 32'(stall_cnt), 32'd121);
    chk("nto_no_err", 32'(terr_cnt), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("nto_valid_pulses", 32'(valid_cnt), 32'd1);
    chk("nto_rdata", rdata, 32'h0BAD_F00D);
`endif

    chk("txq_drained", 32'(txq.size()), 32'd0);
    chk("rdq_drained", 32'(rdq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of BUSY cycles to wait for mem_ack (range 2..255).
REQ-002 clk  input  1  the single system clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 op_ld_or_ldr  input  1  the execute-stage instruction is LD or LDR.
REQ-005 op_st  input  1  the execute-stage instruction is ST.
REQ-006 addr  input  32  the effective address, which is the execute-stage ALU output y.
REQ-007 wdata  input  32  the store data, which is the execute-stage d value.
REQ-008 stall  output  1  holds the pipeline stages up to and including execute.
REQ-009 mem_req  output  1  request to data memory.
REQ-010 mem_we  output  1  write enable, qualified by mem_req.
REQ-011 mem_addr  output  32  registered request address.
REQ-012 mem_wdata  output  32  registered store data.
REQ-013 mem_ack  input  1  memory completion, one-cycle pulse.
REQ-014 mem_rdata  input  32  read data, valid when mem_ack=1 and mem_we=0.
REQ-015 rdata  output  32  captured load data for the memory/writeback stage.
REQ-016 rdata_valid  output  1  one-cycle pulse; rdata is valid for a completed load.
REQ-017 timeout_err  output  1  one-cycle pulse on an access abandoned for timeout.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-019 In IDLE with op_ld_or_ldr|op_st=1, the block SHALL go to BUSY and, at that edge, register mem_addr=addr, mem_wdata=wdata and mem_we=op_st&!op_ld_or_ldr.
- If both op flags are set, load takes priority.
REQ-020 stall SHALL be combinational: (IDLE & (op_ld_or_ldr|op_st)) | BUSY.
- stall SHALL be 0 in DONE, so the pipeline advances exactly once per access.
REQ-021 mem_req SHALL be 1 in BUSY only, driven from registered state.
- mem_addr, mem_wdata and mem_we SHALL be stable throughout BUSY.
REQ-022 In BUSY with mem_ack=1, the block SHALL go to DONE.
- For a load, rdata SHALL capture mem_rdata at that edge.
REQ-023 DONE SHALL last exactly one cycle, then go to IDLE.
- rdata_valid SHALL be 1 in DONE iff the access was a load completed by mem_ack.
REQ-024 Minimum latency with mem_ack in the first BUSY cycle: stall high for 2 cycles (IDLE-detect cycle plus one BUSY cycle), released in cycle 2.
REQ-025 mem_ack in IDLE or DONE SHALL be ignored and SHALL have no effect on any output.
REQ-026 Op flags sampled in BUSY or DONE SHALL NOT start a new access.
- An instruction presented in DONE is re-evaluated in the following IDLE cycle.
REQ-027 rdata SHALL hold its value until the next completed load.
REQ-028 Store completion SHALL NOT pulse rdata_valid and SHALL NOT modify rdata.

Reset
REQ-029 While rst_n=0 at posedge clk, the block SHALL enter IDLE and clear to 0: mem_req, mem_we, mem_addr, mem_wdata, rdata, rdata_valid, timeout_err and the timeout counter.
REQ-030 Reset during BUSY SHALL drop mem_req at that edge.
- An mem_ack arriving after reset SHALL be ignored per REQ-025.
REQ-031 During reset, stall SHALL still follow REQ-020 with state=IDLE; upstream is expected to hold off.

Configuration
REQ-032 Macro MEM_CTRL_TIMEOUT_EN SHALL compile the timeout watchdog in or out.
- Defined:
  - An 8-bit counter clears on BUSY entry and increments each BUSY cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES-1 without mem_ack, the block SHALL drop mem_req, go to DONE, and pulse timeout_err for that DONE cycle.
  - On timeout, rdata SHALL NOT be updated and rdata_valid SHALL be 0.
  - mem_ack in the same cycle as expiry SHALL win: a normal completion with no error.
- Not defined:
  - No counter; BUSY waits indefinitely for mem_ack.
  - timeout_err SHALL be tied to 0.

Verification
REQ-033 Load, zero-wait: op_ld_or_ldr=1, addr=0x100, mem_ack with mem_rdata=0xDEADBEEF in the first BUSY cycle -> mem_req for 1 cycle, stall for 2 cycles, rdata_valid pulse with rdata=0xDEADBEEF.
REQ-034 Store with 3-cycle wait: op_st=1, addr=0x40, wdata=0x12345678, mem_ack in the 3rd BUSY cycle -> mem_we=1, mem_addr/mem_wdata stable for 3 cycles, stall for 4 cycles, no rdata_valid.
REQ-035 Back-to-back loads: a second load is presented in DONE -> a new BUSY starts one cycle after DONE, and each load issues exactly one mem_req burst.
REQ-036 Reset mid-BUSY: rst_n=0 in the 2nd BUSY cycle, then mem_ack 1 cycle later -> IDLE, mem_req=0, no rdata_valid, and rdata stays 0.
REQ-037 With MEM_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req for 4 cycles, timeout_err pulse, stall released next cycle.
- Without the macro, the same stimulus -> stall held for 100+ cycles and timeout_err=0.
REQ-038 Stray ack: mem_ack=1 in IDLE -> no state change and no output change.
